// File: rtl/dbus_ram_ws_if.sv
// Wishbone-classic data-bus bundle between the rv_cpu data port (master)
// and the data RAM slave.
interface dbus_ram_ws_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [29:0] adr;
    logic [31:0] datWr;
    logic [31:0] datRd;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, sel, adr, datWr,
        input  datRd, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, datWr,
        output datRd, ack, err
    );
endinterface

// File: rtl/dbus_ram_ws.sv
// Parametrised 32-bit data RAM slave with programmable wait states, byte-lane
// writes, cycle abort and an error response for addresses outside its window.
module dbus_ram_ws #(
    parameter int          ADDR_WIDTH  = 7,
    parameter logic [29:0] BASE_ADR    = 30'h0,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic         clk_i,
    input  logic         rst_i,
    dbus_ram_ws_if.slave dbus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCEPT, WAIT, RESP} state_e;

    state_e                  state_q;
    logic [3:0]              waitCnt_q;
    logic                    we_q;
    logic [3:0]              sel_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdat_q;
    logic                    hit_q;
    logic                    ack_q;
    logic                    err_q;
    logic [31:0]             rdat_q;

    logic [31:0]             mem [DEPTH];

    logic                    reqHit;
    logic                    enterResp;
    logic                    memWrite;

    // A dropped cyc on the edge that would enter RESP aborts the transfer,
    // so the response and the RAM write are both qualified by cyc.
    always_comb begin
        reqHit    = (dbus.adr >> ADDR_WIDTH) == (BASE_ADR >> ADDR_WIDTH);
        enterResp = 1'b0;
        if (dbus.cyc) begin
            if (state_q == ACCEPT && WAIT_STATES == 0) begin
                enterResp = 1'b1;
            end
            if (state_q == WAIT && waitCnt_q == 4'd0) begin
                enterResp = 1'b1;
            end
        end
        memWrite = enterResp & hit_q & we_q & ~rst_i;
    end

    // RAM contents survive reset.
    always_ff @(posedge clk_i) begin
        if (memWrite) begin
            for (int n = 0; n < 4; n++) begin
                if (sel_q[n]) begin
                    mem[idx_q][8*n +: 8] <= wdat_q[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= 32'h0;
        end else begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            rdat_q <= 32'h0;

            case (state_q)
                IDLE: begin
                    if (dbus.cyc && dbus.stb) begin
                        we_q    <= dbus.we;
                        sel_q   <= dbus.sel;
                        idx_q   <= dbus.adr[ADDR_WIDTH-1:0];
                        wdat_q  <= dbus.datWr;
                        hit_q   <= reqHit;
                        state_q <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (!dbus.cyc) begin
                        state_q <= IDLE;
                    end else if (WAIT_STATES == 0) begin
                        state_q <= RESP;
                    end else begin
                        state_q   <= WAIT;
                        waitCnt_q <= 4'(WAIT_STATES - 1);
                    end
                end
                WAIT: begin
                    if (!dbus.cyc) begin
                        state_q <= IDLE;
                    end else if (waitCnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        waitCnt_q <= waitCnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (enterResp) begin
                if (hit_q) begin
                    ack_q <= 1'b1;
                    if (!we_q) begin
                        rdat_q <= mem[idx_q];
                    end
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign dbus.ack   = ack_q;
    assign dbus.err   = err_q;
    assign dbus.datRd = rdat_q;
endmodule

// File: tb/tb_dbus_ram_ws.sv
// Scoreboard bench for dbus_ram_ws: three instances (0 wait states / base 0,
// 3 wait states / base 0x100, 2 wait states / base 0) driven by directed vectors.
module tb_dbus_ram_ws;
    typedef struct {
        logic        isErr;
        logic [31:0] data;
        int          cycle;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cyc;
    logic [2:0]  stb;
    logic [2:0]  we;
    logic [3:0]  sel   [3];
    logic [29:0] adr   [3];
    logic [31:0] datWr [3];
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [31:0] datRd [3];

    int    cycle      = 0;
    int    compared   = 0;
    int    mismatched = 0;
    resp_t q0[$];
    resp_t q1[$];
    resp_t q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    for (genvar g = 0; g < 3; g++) begin : gInst
        dbus_ram_ws_if bus ();

        assign bus.cyc   = cyc[g];
        assign bus.stb   = stb[g];
        assign bus.we    = we[g];
        assign bus.sel   = sel[g];
        assign bus.adr   = adr[g];
        assign bus.datWr = datWr[g];
        assign ack[g]    = bus.ack;
        assign err[g]    = bus.err;
        assign datRd[g]  = bus.datRd;

        dbus_ram_ws #(
            .ADDR_WIDTH  (7),
            .BASE_ADR    ((g == 1) ? 30'h100 : 30'h0),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
            .INIT_FILE   ("")
        ) dut (
            .clk_i (clk),
            .rst_i (rst),
            .dbus  (bus.slave)
        );
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic void pushExp(input int inst, input resp_t e);
        case (inst)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic bit popExp(input int inst, output resp_t e);
        popExp = 1'b0;
        e = '{1'b0, 32'h0, 0};
        case (inst)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); popExp = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); popExp = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); popExp = 1'b1; end
        endcase
    endfunction

    // Monitor: every ack/err pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        resp_t e;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (ack[i] === 1'b1 || err[i] === 1'b1) begin
                    if (!popExp(i, e)) begin
                        checkOutput($sformatf("unexpected response inst%0d {ack,err}", i),
                                    32'({ack[i], err[i]}), 32'h0);
                    end else begin
                        checkOutput($sformatf("inst%0d err flag", i), 32'(err[i]), 32'(e.isErr));
                        checkOutput($sformatf("inst%0d ack flag", i), 32'(ack[i]), 32'(!e.isErr));
                        checkOutput($sformatf("inst%0d read data", i), datRd[i], e.data);
                        checkOutput($sformatf("inst%0d response cycle", i), 32'(cycle), 32'(e.cycle));
                    end
                end
            end
        end
    end

    function automatic int waitStates(input int inst);
        return (inst == 0) ? 0 : ((inst == 1) ? 3 : 2);
    endfunction

    // Single transfer; called on a falling edge with the slave idle.
    task automatic applyStimulus(input int inst, input bit wr, input logic [3:0] s,
                                 input logic [29:0] a, input logic [31:0] d,
                                 input bit expErr, input logic [31:0] expData);
        resp_t e;
        int    budget;
        cyc[inst]   = 1'b1;
        stb[inst]   = 1'b1;
        we[inst]    = wr;
        sel[inst]   = s;
        adr[inst]   = a;
        datWr[inst] = d;
        e.isErr = expErr;
        e.data  = expData;
        e.cycle = cycle + 2 + waitStates(inst);
        pushExp(inst, e);
        @(posedge clk);
        #1 stb[inst] = 1'b0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(ack[inst] === 1'b1 || err[inst] === 1'b1) && budget < 40);
        checkOutput($sformatf("inst%0d response seen", inst), 32'(ack[inst] | err[inst]), 32'h1);
        cyc[inst] = 1'b0;
        we[inst]  = 1'b0;
        @(negedge clk);
        checkOutput($sformatf("inst%0d response cleared", inst), 32'({ack[inst], err[inst]}), 32'h0);
        checkOutput($sformatf("inst%0d dat cleared", inst), datRd[inst], 32'h0);
    endtask

    // Write that is abandoned by dropping cyc a given number of edges after acceptance.
    task automatic abortWrite(input int inst, input logic [29:0] a, input int dropAfter);
        cyc[inst]   = 1'b1;
        stb[inst]   = 1'b1;
        we[inst]    = 1'b1;
        sel[inst]   = 4'hF;
        adr[inst]   = a;
        datWr[inst] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 stb[inst] = 1'b0;
        repeat (dropAfter) @(posedge clk);
        #1 cyc[inst] = 1'b0;
        we[inst] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput($sformatf("inst%0d abort quiet", inst), 32'({ack[inst], err[inst]}), 32'h0);
        end
    endtask

    // Four reads on instance 1 with stb held, stepping the address after each ack.
    task automatic streamReads();
        resp_t e;
        int    k0;
        int    budget;
        k0     = cycle + 1;
        cyc[1] = 1'b1;
        stb[1] = 1'b1;
        we[1]  = 1'b0;
        sel[1] = 4'hF;
        adr[1] = 30'h100;
        for (int j = 0; j < 4; j++) begin
            e.isErr = 1'b0;
            e.data  = 32'hCAFE_0100 + 32'(j);
            e.cycle = k0 + 4 + 6 * j;
            pushExp(1, e);
        end
        for (int j = 0; j < 4; j++) begin
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (ack[1] !== 1'b1 && budget < 40);
            checkOutput($sformatf("stream ack %0d seen", j), 32'(ack[1]), 32'h1);
            adr[1] = 30'h100 + 30'(j + 1);
        end
        checkOutput("stream length in cycles", 32'(cycle - k0 + 2), 32'd24);
        cyc[1] = 1'b0;
        stb[1] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        cyc = '0;
        stb = '0;
        we  = '0;
        for (int i = 0; i < 3; i++) begin
            sel[i]   = 4'h0;
            adr[i]   = 30'h0;
            datWr[i] = 32'h0;
        end
        cyc[0]   = 1'b1;
        stb[0]   = 1'b1;
        we[0]    = 1'b1;
        sel[0]   = 4'hF;
        adr[0]   = 30'd9;
        datWr[0] = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset ack", 32'(ack[0]), 32'h0);
            checkOutput("reset err", 32'(err[0]), 32'h0);
            checkOutput("reset dat", datRd[0], 32'h0);
        end
        rst    = 1'b0;
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        we[0]  = 1'b0;
        @(negedge clk);

        $display("[TB] zero wait states, byte lanes, window on instance 0");
        applyStimulus(0, 1'b1, 4'hF,    30'd5,   32'hDEAD_BEEF, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 4'hF,    30'd5,   32'h0,         1'b0, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b1, 4'hF,    30'd8,   32'h1234_5678, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 4'b0101, 30'd8,   32'hAABB_CCDD, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 4'hF,    30'd8,   32'h0,         1'b0, 32'h12BB_56DD);
        applyStimulus(0, 1'b1, 4'h0,    30'd8,   32'hFFFF_FFFF, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 4'h0,    30'd8,   32'h0,         1'b0, 32'h12BB_56DD);
        applyStimulus(0, 1'b1, 4'hF,    30'h85,  32'hFFFF_FFFF, 1'b1, 32'h0);
        applyStimulus(0, 1'b0, 4'hF,    30'd5,   32'h0,         1'b0, 32'hDEAD_BEEF);
        abortWrite(0, 30'd5, 0);
        applyStimulus(0, 1'b0, 4'hF,    30'd5,   32'h0,         1'b0, 32'hDEAD_BEEF);

        $display("[TB] reset with a pending write request");
        applyStimulus(0, 1'b1, 4'hF, 30'd9, 32'h1111_1111, 1'b0, 32'h0);
        rst      = 1'b1;
        cyc[0]   = 1'b1;
        stb[0]   = 1'b1;
        we[0]    = 1'b1;
        sel[0]   = 4'hF;
        adr[0]   = 30'd9;
        datWr[0] = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            checkOutput("reset hold ack/err", 32'({ack[0], err[0]}), 32'h0);
        end
        rst    = 1'b0;
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        we[0]  = 1'b0;
        @(negedge clk);
        applyStimulus(0, 1'b0, 4'hF, 30'd9, 32'h0, 1'b0, 32'h1111_1111);

        $display("[TB] three wait states and base 0x100 on instance 1");
        for (int j = 0; j < 4; j++) begin
            applyStimulus(1, 1'b1, 4'hF, 30'h100 + 30'(j), 32'hCAFE_0100 + 32'(j), 1'b0, 32'h0);
        end
        streamReads();
        applyStimulus(1, 1'b1, 4'hF, 30'h080, 32'hFFFF_FFFF, 1'b1, 32'h0);
        applyStimulus(1, 1'b0, 4'hF, 30'h100, 32'h0,         1'b0, 32'hCAFE_0100);
        applyStimulus(1, 1'b1, 4'hF, 30'h105, 32'h55AA_55AA, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 4'hF, 30'h105, 32'h0,         1'b0, 32'h55AA_55AA);
        applyStimulus(1, 1'b0, 4'hF, 30'h005, 32'h0,         1'b1, 32'h0);

        $display("[TB] aborts with two wait states on instance 2");
        applyStimulus(2, 1'b1, 4'hF, 30'd3, 32'h0123_4567, 1'b0, 32'h0);
        abortWrite(2, 30'd3, 1);
        applyStimulus(2, 1'b0, 4'hF, 30'd3, 32'h0,         1'b0, 32'h0123_4567);
        abortWrite(2, 30'd3, 2);
        applyStimulus(2, 1'b0, 4'hF, 30'd3, 32'h0,         1'b0, 32'h0123_4567);
        applyStimulus(2, 1'b1, 4'hF, 30'd3, 32'h89AB_CDEF, 1'b0, 32'h0);
        applyStimulus(2, 1'b0, 4'hF, 30'd3, 32'h0,         1'b0, 32'h89AB_CDEF);

        repeat (3) @(negedge clk);
        checkOutput("pending expectations", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
